mdc_delay_commutator: RTL and testbench

Parametrised delay-commutator stage for the radix-2 MDC FFT pipeline, replacing the purely combinational swap with the full stage: lower-path input delay line, counter-driven swap, upper-path output delay line. Pairs complex samples DEPTH apart on two lanes, so the following butterfly sees aligned operands. Includes a registered bypass mode and valid tracking so stages of different DEPTH chain directly.

---
 rtl/fft_mdc_pkg.sv | 20 ++
 rtl/mdc_delay_commutator_if.sv | 27 ++
 rtl/mdc_delay_line.sv | 29 ++
 rtl/mdc_delay_commutator.sv | 103 ++++++++++
 tb/tb_mdc_delay_commutator.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_mdc_pkg.sv
// rtl/fft_mdc_pkg.sv - shared types and helpers for the radix-2 MDC FFT pipeline
package fft_mdc_pkg;

    localparam int CPLX_W = 9;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdc_delay_commutator_if.sv
// rtl/mdc_delay_commutator_if.sv - sample-pair stream bundle for one commutator stage
interface mdc_delay_commutator_if #(
    parameter int WIDTH = 9
);
    logic                    mode;
    logic                    in_valid;
    logic signed [WIDTH-1:0] inUI_re;
    logic signed [WIDTH-1:0] inUI_im;
    logic signed [WIDTH-1:0] inLI_re;
    logic signed [WIDTH-1:0] inLI_im;
    logic signed [WIDTH-1:0] Up_out_re;
    logic signed [WIDTH-1:0] Up_out_im;
    logic signed [WIDTH-1:0] Low_out_re;
    logic signed [WIDTH-1:0] Low_out_im;
    logic                    out_valid;

    modport master (
        output mode, in_valid, inUI_re, inUI_im, inLI_re, inLI_im,
        input  Up_out_re, Up_out_im, Low_out_re, Low_out_im, out_valid
    );

    modport slave (
        input  mode, in_valid, inUI_re, inUI_im, inLI_re, inLI_im,
        output Up_out_re, Up_out_im, Low_out_re, Low_out_im, out_valid
    );

endinterface

// File: rtl/mdc_delay_line.sv
// rtl/mdc_delay_line.sv - DEPTH-entry complex shift register advancing on enable
module mdc_delay_line #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] din_re,
    input  logic signed [WIDTH-1:0] din_im,
    output logic signed [WIDTH-1:0] dout_re,
    output logic signed [WIDTH-1:0] dout_im
);

    // Contents are deliberately not reset; the stage's fill counter masks stale entries.
    logic [2*WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            taps[0] <= {din_re, din_im};
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout_re = taps[DEPTH-1][2*WIDTH-1:WIDTH];
    assign dout_im = taps[DEPTH-1][WIDTH-1:0];

endmodule

// File: rtl/mdc_delay_commutator.sv
// rtl/mdc_delay_commutator.sv - radix-2 MDC delay-commutator stage with bypass and valid tracking
module mdc_delay_commutator
    import fft_mdc_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mdc_delay_commutator_if.slave  bus
);

    localparam int CW = clog2(DEPTH) + 1;

    logic [CW-1:0]           cnt;
    logic [CW-1:0]           fill;
    logic                    prev_mode;
    logic                    accept;
    logic                    restart;
    logic                    shift;
    logic [CW-1:0]           cnt_cur;
    logic [CW-1:0]           fill_cur;
    logic                    sel;
    logic                    primed;
    logic signed [WIDTH-1:0] ld_re, ld_im;
    logic signed [WIDTH-1:0] p_re, p_im, q_re, q_im;
    logic signed [WIDTH-1:0] pd_re, pd_im;

    assign accept  = bus.in_valid;
    // A 1->0 mode change on an accepted sample makes that sample n = 0.
    assign restart = accept && !bus.mode && prev_mode;
    assign shift   = accept && !bus.mode;

    assign cnt_cur  = restart ? '0 : cnt;
    assign fill_cur = restart ? '0 : fill;
    assign sel      = cnt_cur[CW-1];
    assign primed   = (fill_cur == CW'(DEPTH));

    mdc_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_line_a (
        .clk     (clk),
        .en      (shift),
        .din_re  (bus.inLI_re),
        .din_im  (bus.inLI_im),
        .dout_re (ld_re),
        .dout_im (ld_im)
    );

    always_comb begin
        p_re = bus.inUI_re;
        p_im = bus.inUI_im;
        q_re = ld_re;
        q_im = ld_im;
        if (sel) begin
            p_re = ld_re;
            p_im = ld_im;
            q_re = bus.inUI_re;
            q_im = bus.inUI_im;
        end
    end

    mdc_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_line_b (
        .clk     (clk),
        .en      (shift),
        .din_re  (p_re),
        .din_im  (p_im),
        .dout_re (pd_re),
        .dout_im (pd_im)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt            <= '0;
            fill           <= '0;
            prev_mode      <= 1'b0;
            bus.Up_out_re  <= '0;
            bus.Up_out_im  <= '0;
            bus.Low_out_re <= '0;
            bus.Low_out_im <= '0;
            bus.out_valid  <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (accept) begin
                prev_mode <= bus.mode;
                if (bus.mode) begin
                    bus.Up_out_re  <= bus.inUI_re;
                    bus.Up_out_im  <= bus.inUI_im;
                    bus.Low_out_re <= bus.inLI_re;
                    bus.Low_out_im <= bus.inLI_im;
                    bus.out_valid  <= 1'b1;
                end else begin
                    cnt            <= cnt_cur + 1'b1;
                    fill           <= primed ? fill_cur : fill_cur + 1'b1;
                    bus.Up_out_re  <= pd_re;
                    bus.Up_out_im  <= pd_im;
                    bus.Low_out_re <= q_re;
                    bus.Low_out_im <= q_im;
                    bus.out_valid  <= primed;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdc_delay_commutator.sv
// tb/tb_mdc_delay_commutator.sv - scoreboard bench for three commutator stages of different depth
module tb_mdc_delay_commutator;
    import fft_mdc_pkg::*;

    localparam int W  = 9;
    localparam int NL = 3;
    localparam int DEPTHS [NL] = '{4, 2, 16};

    typedef struct packed {
        logic  valid;
        cplx_t up;
        cplx_t low;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  mode_d;
    logic  valid_d;
    cplx_t u_d;
    cplx_t l_d;
    logic  done = 1'b0;

    cplx_t up_o  [NL];
    cplx_t low_o [NL];
    logic  ov    [NL];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : lane
        mdc_delay_commutator_if #(.WIDTH(W)) bus ();
        assign bus.mode     = mode_d;
        assign bus.in_valid = valid_d;
        assign bus.inUI_re  = u_d.re;
        assign bus.inUI_im  = u_d.im;
        assign bus.inLI_re  = l_d.re;
        assign bus.inLI_im  = l_d.im;
        assign up_o[g]  = {bus.Up_out_re, bus.Up_out_im};
        assign low_o[g] = {bus.Low_out_re, bus.Low_out_im};
        assign ov[g]    = bus.out_valid;

        mdc_delay_commutator #(.WIDTH(W), .DEPTH(DEPTHS[g])) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // Reference: inputs of the current segment kept as plain history; the
    // output pair for sample n is read straight from the pairing rule.
    cplx_t hu[$];
    cplx_t hl[$];
    logic  m_prev = 1'b0;
    exp_t  sb [NL][$];

    function automatic cplx_t mk(input int re, input int im);
        cplx_t c;
        c.re = W'(re);
        c.im = W'(im);
        return c;
    endfunction

    function automatic logic [W-1:0] rv();
        case ($urandom_range(0, 2))
            0:       return 9'h100;
            1:       return 9'h0FF;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic cplx_t rc();
        cplx_t c;
        c.re = rv();
        c.im = rv();
        return c;
    endfunction

    task automatic step(input logic r, input logic v, input logic m, input cplx_t u, input cplx_t l);
        exp_t e;
        int   n;
        rst_n   = r;
        valid_d = v;
        mode_d  = m;
        u_d     = u;
        l_d     = l;
        if (!r) begin
            hu.delete();
            hl.delete();
            m_prev = 1'b0;
        end else if (v) begin
            if (m) begin
                m_prev = 1'b1;
                e.valid = 1'b1;
                e.up    = u;
                e.low   = l;
                for (int g = 0; g < NL; g++) sb[g].push_back(e);
            end else begin
                if (m_prev) begin
                    hu.delete();
                    hl.delete();
                end
                m_prev = 1'b0;
                n = hu.size();
                hu.push_back(u);
                hl.push_back(l);
                for (int g = 0; g < NL; g++) begin
                    int d;
                    d = DEPTHS[g];
                    e = '0;
                    if (n >= d) begin
                        e.valid = 1'b1;
                        if ((n / d) % 2 == 1) begin
                            e.up  = hu[n-d];
                            e.low = hu[n];
                        end else begin
                            e.up  = hl[n-2*d];
                            e.low = hl[n-d];
                        end
                    end
                    sb[g].push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic  app_rst   = 1'b1;
    logic  app_valid = 1'b0;
    cplx_t held_up  [NL];
    cplx_t held_low [NL];
    int    n_checks = 0;
    int    n_fail   = 0;
    exp_t  act;
    exp_t  want;
    logic  ok;
    string tag;

    always @(posedge clk) begin
        app_rst   <= rst_n;
        app_valid <= valid_d;
    end

    always @(negedge clk) begin
        for (int g = 0; g < NL; g++) begin
            act.valid = ov[g];
            act.up    = up_o[g];
            act.low   = low_o[g];
            if (!app_rst) begin
                tag  = "reset";
                want = '0;
                ok   = (act === want);
            end else if (!app_valid) begin
                tag  = "hold";
                want.valid = 1'b0;
                want.up    = held_up[g];
                want.low   = held_low[g];
                ok   = (act === want);
            end else if (sb[g].size() == 0) begin
                tag  = "unexpected_output";
                want = '0;
                ok   = 1'b0;
            end else begin
                tag  = "pair";
                want = sb[g].pop_front();
                ok   = (act.valid === want.valid) && (!want.valid || act === want);
            end
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s D=%0d t=%0t: got v=%0b up=(%0d,%0d) low=(%0d,%0d) want v=%0b up=(%0d,%0d) low=(%0d,%0d)",
                         tag, DEPTHS[g], $time, act.valid, act.up.re, act.up.im, act.low.re, act.low.im,
                         want.valid, want.up.re, want.up.im, want.low.re, want.low.im);
            end
            held_up[g]  = up_o[g];
            held_low[g] = low_o[g];
        end
        if (done) begin
            for (int g = 0; g < NL; g++) begin
                n_checks++;
                if (sb[g].size() != 0) begin
                    n_fail++;
                    $display("FAIL drain D=%0d: got %0d pending outputs want 0", DEPTHS[g], sb[g].size());
                end
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        logic mode_r;
        rst_n   = 1'b0;
        valid_d = 1'b1;
        mode_d  = 1'b0;
        u_d     = '0;
        l_d     = '0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, rc(), rc());

        for (int n = 0; n < 40; n++) step(1'b1, 1'b1, 1'b0, mk(n, -n), mk(100 + n, n));

        step(1'b0, 1'b0, 1'b0, '0, '0);
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 1'b1, 1'b0, mk(n, -n), mk(100 + n, n));
            step(1'b1, 1'b0, 1'b0, rc(), rc());
        end

        step(1'b1, 1'b1, 1'b1, mk(-5, 3), mk(7, -2));
        for (int n = 0; n < 20; n++) step(1'b1, 1'b1, 1'b0, mk(n + 20, n), mk(-n, 50));

        step(1'b0, 1'b0, 1'b0, '0, '0);
        for (int n = 0; n < 6; n++) step(1'b1, 1'b1, 1'b0, mk(n, 0), mk(100 + n, 0));
        step(1'b0, 1'b1, 1'b0, rc(), rc());
        for (int n = 0; n < 40; n++) step(1'b1, 1'b1, 1'b0, mk(n, -n), mk(100 + n, n));

        mode_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) mode_r = ~mode_r;
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), mode_r, rc(), rc());
        end

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
        done = 1'b1;
    end

endmodule
